// File: rtl/sm_result_sink.sv
// sm_result_sink: consumer endpoint for the stack machine result stream.
// Captures {err_code, out_data} words into a FIFO, serves them through a
// valid/ready port as a registered first-word fall-through, and keeps
// saturating run statistics.
// Optional feature: define SM_SINK_CHECKSUM_EN to build the running checksum
// of error-free captured words; otherwise checksum_o is tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for the first result word or an empty-program fin
// S_RUN   | program running, words being captured
// S_DRAIN | fin seen, still capturing until the FIFO has emptied
// S_DONE  | FIFO drained after fin; new words are dropped until clear
module sm_result_sink #(
    parameter int DEPTH = 8,
    parameter int DW    = 20,
    parameter int CW    = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     d_valid_i,
    input  logic [DW-1:0]            out_data_i,
    input  logic [2:0]               err_code_i,
    input  logic                     fin_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [DW+2:0]            rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CW-1:0]            res_cnt_o,
    output logic [CW-1:0]            err_cnt_o,
    output logic [CW-1:0]            drop_cnt_o,
    output logic                     overflow_o,
    output logic                     done_o,
    output logic [DW-1:0]            checksum_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              fin_q, fin_d;
    logic [DW+2:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [CW-1:0]     res_cnt_q, res_cnt_d;
    logic [CW-1:0]     err_cnt_q, err_cnt_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    logic              pop, full, in_done, wr, drop, fin_rise;

    assign rd_valid_o = (level_q != '0);
    assign pop        = rd_valid_o & rd_ready_i;
    assign full       = (level_q == LW'(DEPTH));
    assign in_done    = (state_q == S_DONE);
    // A pop frees the slot the write lands in, so a full FIFO still accepts.
    assign wr         = ~clear_i & d_valid_i & ~in_done & (~full | pop);
    assign drop       = ~clear_i & d_valid_i & (in_done | (full & ~pop));
    assign fin_rise   = fin_i & ~fin_q;

    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;
    assign res_cnt_o  = res_cnt_q;
    assign err_cnt_o  = err_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = overflow_q;
    assign done_o     = in_done;

    // Next-state logic for the sequencing FSM; clear overrides everything.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (fin_rise) state_d = S_DRAIN;
                         else if (d_valid_i) state_d = S_RUN;
                S_RUN:   if (fin_rise) state_d = S_DRAIN;
                S_DRAIN: if ((level_q == '0) && !wr) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping and saturating statistics.
    always_comb begin
        fin_d      = fin_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q + LW'(wr) - LW'(pop);
        res_cnt_d  = res_cnt_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            fin_d      = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            res_cnt_d  = '0;
            err_cnt_d  = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (res_cnt_q != {CW{1'b1}}) res_cnt_d = res_cnt_q + CW'(1);
                if ((err_code_i != 3'b000) && (err_cnt_q != {CW{1'b1}}))
                    err_cnt_d = err_cnt_q + CW'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != {CW{1'b1}}) drop_cnt_d = drop_cnt_q + CW'(1);
            end
        end
    end

    // State and control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fin_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            res_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fin_q      <= fin_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            res_cnt_q  <= res_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are only visible through rd_data while level != 0.
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_ptr_q] <= {err_code_i, out_data_i};
    end

`ifdef SM_SINK_CHECKSUM_EN
    logic [DW-1:0] checksum_q, checksum_d;

    // Modular sum of error-free captured words.
    always_comb begin
        checksum_d = checksum_q;
        if (clear_i) checksum_d = '0;
        else if (wr && (err_code_i == 3'b000)) checksum_d = checksum_q + out_data_i;
    end

    // Checksum register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) checksum_q <= '0;
        else       checksum_q <= checksum_d;
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_sm_result_sink.sv
// Self-checking bench for sm_result_sink: directed scenarios followed by a
// random phase, all compared every cycle against a queue-based model.
module tb_sm_result_sink;

    localparam int DEPTH = 8;
    localparam int DW    = 20;
    localparam int CW    = 10;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            clear_i;
    logic            d_valid_i;
    logic [DW-1:0]   out_data_i;
    logic [2:0]      err_code_i;
    logic            fin_i;
    logic            rd_valid_o;
    logic            rd_ready_i;
    logic [DW+2:0]   rd_data_o;
    logic [3:0]      level_o;
    logic [CW-1:0]   res_cnt_o;
    logic [CW-1:0]   err_cnt_o;
    logic [CW-1:0]   drop_cnt_o;
    logic            overflow_o;
    logic            done_o;
    logic [DW-1:0]   checksum_o;

    sm_result_sink #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .d_valid_i(d_valid_i), .out_data_i(out_data_i), .err_code_i(err_code_i),
        .fin_i(fin_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data_o), .level_o(level_o), .res_cnt_o(res_cnt_o),
        .err_cnt_o(err_cnt_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o),
        .done_o(done_o), .checksum_o(checksum_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW+2:0] m_q[$];
    int            m_res, m_err, m_drop, m_phase;
    bit            m_ovf, m_fin_prev;
    logic [DW-1:0] m_sum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_res = 0; m_err = 0; m_drop = 0; m_phase = P_IDLE;
        m_ovf = 0; m_fin_prev = 0; m_sum = '0;
    endtask

    task automatic model_edge(input bit dv, input logic [DW-1:0] dat, input logic [2:0] ec,
                              input bit fn, input bit rr, input bit clr);
        bit pop, wr, rise;
        if (clr) begin
            model_reset();
            return;
        end
        pop  = (m_q.size() != 0) && rr;
        wr   = dv && (m_phase != P_DONE) && ((m_q.size() < DEPTH) || pop);
        rise = fn && !m_fin_prev;
        if (m_phase == P_IDLE) begin
            if (rise) m_phase = P_DRAIN;
            else if (dv) m_phase = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (rise) m_phase = P_DRAIN;
        end else if (m_phase == P_DRAIN) begin
            if (m_q.size() == 0 && !wr) m_phase = P_DONE;
        end
        if (pop) void'(m_q.pop_front());
        if (wr) begin
            m_q.push_back({ec, dat});
            if (m_res < CMAX) m_res++;
            if (ec != 0 && m_err < CMAX) m_err++;
`ifdef SM_SINK_CHECKSUM_EN
            if (ec == 0) m_sum = m_sum + dat;
`endif
        end
        if (dv && !wr) begin
            m_ovf = 1;
            if (m_drop < CMAX) m_drop++;
        end
        m_fin_prev = fn;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_rd_valid"}, rd_valid_o, m_q.size() != 0);
        check({tag, "_rd_data"}, rd_data_o, (m_q.size() != 0) ? m_q[0] : '0);
        check({tag, "_level"}, level_o, m_q.size());
        check({tag, "_res_cnt"}, res_cnt_o, m_res);
        check({tag, "_err_cnt"}, err_cnt_o, m_err);
        check({tag, "_drop_cnt"}, drop_cnt_o, m_drop);
        check({tag, "_overflow"}, overflow_o, m_ovf);
        check({tag, "_done"}, done_o, m_phase == P_DONE);
        check({tag, "_checksum"}, checksum_o, m_sum);
    endtask

    // One clock cycle: drive at negedge, compare, let the edge happen, update model.
    task automatic step(input bit dv, input logic [DW-1:0] dat, input logic [2:0] ec,
                        input bit fn, input bit rr, input bit clr, input string tag);
        d_valid_i = dv; out_data_i = dat; err_code_i = ec;
        fin_i = fn; rd_ready_i = rr; clear_i = clr;
        #1;
        compare_all(tag);
        @(posedge clk_i);
        model_edge(dv, dat, ec, fn, rr, clr);
        @(negedge clk_i);
    endtask

    logic [DW-1:0] w_new, w_ok, w_keep;
    logic [2:0]    ec_r;
    logic [63:0]   exp_sum;
    bit            fin_r;

    initial begin
        rst_i = 1'b1; clear_i = 0; d_valid_i = 0; out_data_i = '0;
        err_code_i = '0; fin_i = 0; rd_ready_i = 0;
        model_reset();
        @(negedge clk_i);
        #1;
        compare_all("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Three queued entries, then an asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) step(1, DW'($urandom), 3'($urandom_range(0, 1)), 0, 0, 0, "t1_push");
        check("t1_level_before", level_o, 3);
        rst_i = 1'b1;
        #1;
        model_reset();
        compare_all("t1_async");
        @(negedge clk_i);
        rst_i = 1'b0;
        check("t1_level", level_o, 0);
        check("t1_res_cnt", res_cnt_o, 0);
        step(0, '0, 0, 0, 0, 0, "t1_idle");
        check("t1_not_done", done_o, 0);

        // Three ok words, reader always ready, then fin.
        step(1, 20'h00005, 0, 0, 1, 0, "t2_w0");
        check("t2_rd0", rd_data_o, 23'h000005);
        step(1, 20'hFFFFD, 0, 0, 1, 0, "t2_w1");
        check("t2_rd1", rd_data_o, 23'h0FFFFD);
        step(1, 20'h0000C, 0, 0, 1, 0, "t2_w2");
        check("t2_rd2", rd_data_o, 23'h00000C);
        for (int i = 0; i < 20 && done_o !== 1'b1; i++) step(0, '0, 0, 1, 1, 0, "t2_drain");
        check("t2_done", done_o, 1);
        check("t2_res_cnt", res_cnt_o, 3);
        check("t2_err_cnt", err_cnt_o, 0);
`ifdef SM_SINK_CHECKSUM_EN
        check("t2_checksum", checksum_o, 20'h0000E);
`else
        check("t2_checksum", checksum_o, 0);
`endif

        // Stalled reader, DEPTH+2 words.
        step(0, '0, 0, 0, 0, 1, "t3_clear");
        for (int i = 0; i < DEPTH + 2; i++) step(1, DW'($urandom), 0, 0, 0, 0, "t3_push");
        check("t3_level", level_o, 8);
        check("t3_drop_cnt", drop_cnt_o, 2);
        check("t3_overflow", overflow_o, 1);

        // Full FIFO: write and pop in the same cycle.
        w_new = DW'($urandom);
        step(1, w_new, 0, 0, 1, 0, "t4_wrpop");
        check("t4_level", level_o, 8);
        check("t4_drop_cnt", drop_cnt_o, 2);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("t4_last", rd_data_o, {3'b000, w_new});
            step(0, '0, 0, 0, 1, 0, "t4_drain");
        end
        check("t4_empty", rd_valid_o, 0);

        // Error codes.
        step(0, '0, 0, 0, 0, 1, "t5_clear");
        step(1, '0, 3'b001, 0, 0, 0, "t5_e1");
        step(1, '0, 3'b010, 0, 0, 0, "t5_e2");
        step(1, '0, 3'b100, 0, 0, 0, "t5_e4");
        w_ok = DW'($urandom);
        step(1, w_ok, 3'b000, 0, 0, 0, "t5_ok");
        check("t5_err_cnt", err_cnt_o, 3);
        check("t5_res_cnt", res_cnt_o, 4);
`ifdef SM_SINK_CHECKSUM_EN
        exp_sum = 64'(w_ok);
`else
        exp_sum = 64'd0;
`endif
        check("t5_checksum", checksum_o, exp_sum);

        // Reach DONE, drop a word there, then clear.
        for (int i = 0; i < 30 && done_o !== 1'b1; i++) step(0, '0, 0, 1, 1, 0, "t6_drain");
        check("t6_done", done_o, 1);
        step(1, DW'($urandom), 0, 1, 0, 0, "t6_late");
        check("t6_drop_cnt", drop_cnt_o, 1);
        check("t6_rd_valid", rd_valid_o, 0);
        step(0, '0, 0, 0, 0, 1, "t6_clear");
        check("t6_done_clr", done_o, 0);
        check("t6_res_clr", res_cnt_o, 0);
        check("t6_drop_clr", drop_cnt_o, 0);
        w_keep = DW'($urandom);
        step(1, w_keep, 0, 0, 0, 0, "t6_idle_cap");
        check("t6_idle_level", level_o, 1);
        check("t6_idle_data", rd_data_o, {3'b000, w_keep});

        // Random traffic against the model.
        fin_r = 0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: ec_r = 3'b001;
                1: ec_r = 3'b010;
                2: ec_r = 3'b100;
                default: ec_r = 3'b000;
            endcase
            if ($urandom_range(0, 19) == 0) fin_r = ~fin_r;
            step(1'($urandom_range(0, 1)), DW'($urandom), ec_r, fin_r,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 79) == 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
